regularization: RTL and testbench



---
 rtl/regularization_pkg.sv | 17 +
 rtl/regularization_if.sv | 12 +
 rtl/regularization_bit.sv | 62 ++++++
 rtl/regularization.sv | 52 +++++
 tb/tb_regularization.sv | 184 ++++++++++++++++++
 5 files changed

// File: rtl/regularization_pkg.sv
// Shared types and helpers for the regularization sign-bit filter.
// Channel state enum and the counter-width helper used to size counters.
package regularization_pkg;

  typedef enum logic {
    ARMED = 1'b0,
    HOLD  = 1'b1
  } state_t;

  // Bits needed to hold 0..value, never less than one bit.
  function automatic int cnt_width(input int value);
    int w;
    w = (value < 1) ? 0 : $clog2(value + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/regularization_if.sv
// Raw and filtered sign-bit bundle between the switching-surface logic and the filter.
interface regularization_if #(
  parameter int N = 2
);

  logic [N-1:0] i_signal;
  logic [N-1:0] o_signal;

  modport master (output i_signal, input o_signal);
  modport slave  (input i_signal, output o_signal);

endinterface

// File: rtl/regularization_bit.sv
// One filter channel: debounce a sign bit, then blank it for DELAY cycles
// after each accepted edge.
module regularization_bit
  import regularization_pkg::*;
#(
  parameter int DEBOUNCE_TIME = 5,
  parameter int DELAY         = 500
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_sample,
  output logic o_out
);

  localparam int DW = cnt_width(DEBOUNCE_TIME);
  localparam int HW = cnt_width(DELAY);
  localparam logic [DW-1:0] DCNT_LAST = DW'(DEBOUNCE_TIME - 1);
  localparam logic [HW-1:0] HCNT_LOAD = HW'(DELAY);

  state_t          state;
  logic [DW-1:0]   dcnt;
  logic [HW-1:0]   hcnt;
  logic            out;

  // NOTE: all state updates use non-blocking assignments so every register
  // sees the pre-edge values of the others, matching the hardware it models.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state <= ARMED;
      dcnt  <= '0;
      hcnt  <= '0;
      out   <= 1'b0;
    end else begin
      case (state)
        ARMED: begin
          if (i_sample == out) begin
            dcnt <= '0;
          end else if (dcnt < DCNT_LAST) begin
            dcnt <= dcnt + 1'b1;
          end else begin
            out  <= i_sample;
            dcnt <= '0;
            if (DELAY > 0) begin
              hcnt  <= HCNT_LOAD;
              state <= HOLD;
            end
          end
        end
        HOLD: begin
          // Input ignored; the blanking counter alone decides when to re-arm.
          dcnt <= '0;
          if (hcnt != '0) hcnt <= hcnt - 1'b1;
          if (hcnt <= HW'(1)) state <= ARMED;
        end
        default: state <= ARMED;
      endcase
    end
  end

  assign o_out = out;

endmodule

// File: rtl/regularization.sv
// N-channel debounce-and-blanking filter for switching-surface sign bits.
// Optional input synchronizer enabled by defining REGULARIZATION_SYNC_EN.
module regularization
  import regularization_pkg::*;
#(
  parameter int DEBOUNCE_TIME = 5,
  parameter int DELAY         = 500,
  parameter int N             = 2
) (
  input  logic              i_clk,
  input  logic              i_reset,
  regularization_if.slave   bus
);

  logic [N-1:0] sample;
  logic [N-1:0] filt;

`ifdef REGULARIZATION_SYNC_EN
  // Two-flop synchronizer per bit for a source asynchronous to i_clk.
  logic [N-1:0] sync_q1;
  logic [N-1:0] sync_q2;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      sync_q1 <= '0;
      sync_q2 <= '0;
    end else begin
      sync_q1 <= bus.i_signal;
      sync_q2 <= sync_q1;
    end
  end

  assign sample = sync_q2;
`else
  assign sample = bus.i_signal;
`endif

  for (genvar i = 0; i < N; i++) begin : g_chan
    regularization_bit #(
      .DEBOUNCE_TIME (DEBOUNCE_TIME),
      .DELAY         (DELAY)
    ) u_bit (
      .i_clk    (i_clk),
      .i_reset  (i_reset),
      .i_sample (sample[i]),
      .o_out    (filt[i])
    );
  end

  assign bus.o_signal = filt;

endmodule

// File: tb/tb_regularization.sv
// Directed bench for regularization: reset, glitch rejection, blanking,
// channel independence and reset during hold.
module tb_regularization;

`ifdef REGULARIZATION_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;

  regularization_if #(.N(2)) bus ();

  regularization #(
    .DEBOUNCE_TIME (5),
    .DELAY         (500),
    .N             (2)
  ) dut (
    .i_clk   (clk),
    .i_reset (rst),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  // Advance one rising edge and settle past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.i_signal = 2'b00;
    repeat (3) tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.i_signal = 2'b11;
    repeat (3) tick();
    checks++;
    if (bus.o_signal !== 2'b00) begin
      errors++;
      $display("FAIL reset_hold: o_signal=%b expected=%b", bus.o_signal, 2'b00);
    end
    rst = 1'b0;
    for (int e = 1; e <= 5 + LAT; e++) begin
      tick();
      if (e == 4 + LAT) begin
        checks++;
        if (bus.o_signal !== 2'b00) begin
          errors++;
          $display("FAIL reset_release_early e=%0d: o_signal=%b expected=%b", e, bus.o_signal, 2'b00);
        end
      end
    end
    checks++;
    if (bus.o_signal !== 2'b11) begin
      errors++;
      $display("FAIL reset_release_update: o_signal=%b expected=%b", bus.o_signal, 2'b11);
    end
  endtask

  task automatic test_glitch();
    do_reset();
    for (int r = 0; r < 10; r++) begin
      bus.i_signal = 2'b01;
      repeat (4) tick();
      bus.i_signal = 2'b00;
      tick();
      checks++;
      if (bus.o_signal[0] !== 1'b0) begin
        errors++;
        $display("FAIL glitch r=%0d: o_signal[0]=%b expected=0", r, bus.o_signal[0]);
      end
    end
    repeat (LAT + 3) tick();
    checks++;
    if (bus.o_signal !== 2'b00) begin
      errors++;
      $display("FAIL glitch_tail: o_signal=%b expected=%b", bus.o_signal, 2'b00);
    end
  endtask

  task automatic test_blanking();
    do_reset();
    bus.i_signal = 2'b01;
    for (int e = 1; e <= 510 + LAT; e++) begin
      tick();
      if (e == 5) bus.i_signal = 2'b00;
      if (e == 4 + LAT) begin
        checks++;
        if (bus.o_signal[0] !== 1'b0) begin
          errors++;
          $display("FAIL blank_pre_update: o_signal[0]=%b expected=0", bus.o_signal[0]);
        end
      end
      if (e == 5 + LAT || e == 300 || e == 509 + LAT) begin
        checks++;
        if (bus.o_signal[0] !== 1'b1) begin
          errors++;
          $display("FAIL blank_held e=%0d: o_signal[0]=%b expected=1", e, bus.o_signal[0]);
        end
      end
    end
    checks++;
    if (bus.o_signal[0] !== 1'b0) begin
      errors++;
      $display("FAIL blank_release: o_signal[0]=%b expected=0", bus.o_signal[0]);
    end
  endtask

  task automatic test_independence();
    logic [1:0] exp;
    do_reset();
    bus.i_signal = 2'b01;
    for (int e = 1; e <= 8 + LAT; e++) begin
      tick();
      if (e == 3) bus.i_signal = 2'b11;
      exp = 2'b00;
      if (e >= 5 + LAT) exp[0] = 1'b1;
      if (e >= 8 + LAT) exp[1] = 1'b1;
      if (e == 4 + LAT || e == 5 + LAT || e == 7 + LAT || e == 8 + LAT) begin
        checks++;
        if (bus.o_signal !== exp) begin
          errors++;
          $display("FAIL indep e=%0d: o_signal=%b expected=%b", e, bus.o_signal, exp);
        end
      end
    end
  endtask

  task automatic test_reset_mid_hold();
    do_reset();
    bus.i_signal = 2'b01;
    repeat (5 + LAT) tick();
    checks++;
    if (bus.o_signal !== 2'b01) begin
      errors++;
      $display("FAIL midhold_update: o_signal=%b expected=%b", bus.o_signal, 2'b01);
    end
    repeat (99) tick();
    rst = 1'b1;
    bus.i_signal = 2'b00;
    tick();
    checks++;
    if (bus.o_signal !== 2'b00) begin
      errors++;
      $display("FAIL midhold_reset: o_signal=%b expected=%b", bus.o_signal, 2'b00);
    end
    rst = 1'b0;
    bus.i_signal = 2'b01;
    repeat (4 + LAT) tick();
    checks++;
    if (bus.o_signal !== 2'b00) begin
      errors++;
      $display("FAIL midhold_early: o_signal=%b expected=%b", bus.o_signal, 2'b00);
    end
    tick();
    checks++;
    if (bus.o_signal !== 2'b01) begin
      errors++;
      $display("FAIL midhold_rearm: o_signal=%b expected=%b", bus.o_signal, 2'b01);
    end
  endtask

  initial begin
    bus.i_signal = 2'b00;
    test_reset();
    test_glitch();
    test_blanking();
    test_independence();
    test_reset_mid_hold();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
